// File: rtl/instr_loader_pkg.sv
// Shared state definitions for the instruction loader and the processor blocks:
// loader FSM encoding, the default NOP word, byte-lane constants and a header check.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHECK   = 3'd3,
    ST_RUN     = 3'd4,
    ST_ERROR   = 3'd5
  } state_e;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  // Lane index of the byte that completes a big-endian word.
  localparam logic [1:0] LANE_LAST = 2'd3;

  // A program header is usable when it names 1..depth words.
  function automatic logic header_ok(input logic [7:0] n, input logic [7:0] depth);
    return (n != 8'd0) && (n <= depth);
  endfunction

endpackage

// File: rtl/instr_loader_imem.sv
// Instruction memory: DEPTH x 32, one synchronous write port, one combinational read port.
// Out-of-range addresses are ignored on write and read back as zero.
module instr_loader_imem #(
  parameter int DEPTH = 32
) (
  input  logic        clk,
  input  logic        we,
  input  logic [7:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [7:0]  raddr,
  output logic [31:0] rdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we && (waddr < DEPTH_B)) begin
      mem_q[waddr[AW-1:0]] <= wdata;
    end
  end

  assign rdata = (raddr < DEPTH_B) ? mem_q[raddr[AW-1:0]] : 32'h0000_0000;

endmodule

// File: rtl/instr_loader.sv
// Serial program loader: header byte N, then 4N big-endian payload bytes into imem.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int          DEPTH    = 32,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic [7:0]  PC,
  output logic [0:31] instruction,
  output logic        proc_run,
  output logic        load_error,
  output logic [7:0]  word_count
);

  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  state_e      state_q, state_d;
  logic [9:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  wc_q, wc_d;
  logic [23:0] acc_q, acc_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic        accept;
  logic        last_byte;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  assign accept    = byte_valid && byte_ready;
  assign last_byte = (byte_cnt_q[1:0] == LANE_LAST) && (byte_cnt_q[9:2] == (wc_q - 8'd1));
  assign mem_we    = (state_q == ST_PAYLOAD) && accept && (byte_cnt_q[1:0] == LANE_LAST);
  assign mem_wdata = {acc_q, byte_in};

  instr_loader_imem #(
    .DEPTH (DEPTH)
  ) u_imem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (byte_cnt_q[9:2]),
    .wdata (mem_wdata),
    .raddr (PC),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    wc_d       = wc_q;
    acc_d      = acc_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    byte_ready = 1'b0;

    case (state_q)
      ST_IDLE, ST_RUN, ST_ERROR: begin
        if (load_start) begin
          state_d = ST_HEADER;
        end
      end

      ST_HEADER: begin
        byte_ready = 1'b1;
        if (accept) begin
          byte_cnt_d = 10'd0;
`ifdef LOADER_CHECKSUM_EN
          csum_d     = 8'd0;
`endif
          if (header_ok(byte_in, DEPTH_B)) begin
            wc_d    = byte_in;
            state_d = ST_PAYLOAD;
          end else begin
            state_d = ST_ERROR;
          end
        end
      end

      ST_PAYLOAD: begin
        byte_ready = 1'b1;
        if (accept) begin
          byte_cnt_d = byte_cnt_q + 10'd1;
          acc_d      = {acc_q[15:0], byte_in};
`ifdef LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ byte_in;
          if (last_byte) state_d = ST_CHECK;
`else
          if (last_byte) state_d = ST_RUN;
`endif
        end
      end

`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: begin
        byte_ready = 1'b1;
        if (accept) begin
          state_d = (byte_in == csum_q) ? ST_RUN : ST_ERROR;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= 10'd0;
      wc_q       <= 8'd0;
      acc_q      <= 24'd0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      wc_q       <= wc_d;
      acc_q      <= acc_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // Words beyond the current program are stale from earlier loads and must stay hidden.
  always_comb begin
    instruction = NOP_WORD;
    if ((state_q == ST_RUN) && (PC < wc_q)) begin
      instruction = mem_rdata;
    end
  end

  assign proc_run   = (state_q == ST_RUN);
  assign load_error = (state_q == ST_ERROR);
  assign word_count = wc_q;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: a program-level reference model predicts outputs,
// probes queue expectations and a negedge monitor compares them against the DUT.
module tb_instr_loader;

  localparam int          DEPTH = 32;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  localparam int M_IDLE = 0;
  localparam int M_HDR  = 1;
  localparam int M_PAY  = 2;
  localparam int M_CHK  = 3;
  localparam int M_RUN  = 4;
  localparam int M_ERR  = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [7:0]  PC;
  logic [0:31] instruction;
  logic        proc_run;
  logic        load_error;
  logic [7:0]  word_count;

  instr_loader #(
    .DEPTH    (DEPTH),
    .NOP_WORD (NOP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_start  (load_start),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .PC          (PC),
    .instruction (instruction),
    .proc_run    (proc_run),
    .load_error  (load_error),
    .word_count  (word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [7:0]  wc;
    logic        rdy;
    logic        run;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        probe_req = 1'b0;

  // Reference model: what the loader should present, at program level.
  int          m_mode = M_IDLE;
  logic [7:0]  m_wc   = 8'd0;
  logic [31:0] m_words [256];
  logic [7:0]  pl_q[$];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endfunction

  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [31:0] act_i;
    if (probe_req) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty actual=0 entries required=1 entry");
      end else begin
        e     = sb_q.pop_front();
        act_i = instruction;
        chk({e.name, ".instruction"}, act_i, e.instr);
        chk({e.name, ".word_count"}, {24'd0, word_count}, {24'd0, e.wc});
        chk({e.name, ".byte_ready"}, {31'd0, byte_ready}, {31'd0, e.rdy});
        chk({e.name, ".proc_run"}, {31'd0, proc_run}, {31'd0, e.run});
        chk({e.name, ".load_error"}, {31'd0, load_error}, {31'd0, e.err});
      end
    end
  end

  task automatic probe(input string nm, input logic [7:0] pc);
    exp_t e;
    PC      = pc;
    e.name  = nm;
    e.instr = ((m_mode == M_RUN) && (pc < m_wc)) ? m_words[pc] : NOP;
    e.wc    = m_wc;
    e.rdy   = (m_mode == M_HDR) || (m_mode == M_PAY) || (m_mode == M_CHK);
    e.run   = (m_mode == M_RUN);
    e.err   = (m_mode == M_ERR);
    sb_q.push_back(e);
    probe_req = 1'b1;
    @(posedge clk); #1;
    probe_req = 1'b0;
  endtask

  // gap_mode: 0 = back-to-back, 1 = one idle cycle before each byte, 2 = random gaps.
  task automatic send_byte(input logic [7:0] b, input int gap_mode);
    int gaps;
    bit acc;
    int cyc;
    gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
    repeat (gaps) begin
      byte_valid = 1'b0;
      @(posedge clk); #1;
    end
    byte_in    = b;
    byte_valid = 1'b1;
    acc        = 1'b0;
    cyc        = 0;
    while (!acc && cyc < 40) begin
      @(negedge clk);
      acc = byte_ready;
      @(posedge clk); #1;
      cyc++;
    end
    byte_valid = 1'b0;
    byte_in    = 8'($urandom);
    chk("byte_accept", {31'd0, acc}, 32'd1);
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    if (m_mode == M_IDLE || m_mode == M_RUN || m_mode == M_ERR) m_mode = M_HDR;
  endtask

  // Loads header n and payload pl_q; stop_after >= 0 abandons after that many payload bytes.
  task automatic send_load(input logic [7:0] n, input int gap_mode, input int stop_after,
                           input bit bad_csum, input bit mid_poke);
    logic [7:0] cs;
    int         total;
    pulse_start();
    send_byte(n, gap_mode);
    if (n == 8'd0 || int'(n) > DEPTH) begin
      m_mode = M_ERR;
      $display("load n=%0d rejected at header", n);
      return;
    end
    m_wc   = n;
    m_mode = M_PAY;
    total  = 4 * int'(n);
    cs     = 8'd0;
    for (int i = 0; i < total; i++) begin
      if (stop_after >= 0 && i == stop_after) begin
        $display("load n=%0d abandoned after %0d payload bytes", n, i);
        return;
      end
      if (mid_poke && i == 2) begin
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        probe("mid_load", 8'd0);
      end
      send_byte(pl_q[i], gap_mode);
      cs ^= pl_q[i];
      if (i % 4 == 3) m_words[i / 4] = {pl_q[i-3], pl_q[i-2], pl_q[i-1], pl_q[i]};
    end
`ifdef LOADER_CHECKSUM_EN
    m_mode = M_CHK;
    send_byte(cs ^ {7'd0, bad_csum}, gap_mode);
    m_mode = bad_csum ? M_ERR : M_RUN;
`else
    m_mode = M_RUN;
`endif
    $display("load n=%0d gap_mode=%0d complete csum=%h bad_csum=%0d", n, gap_mode, cs, bad_csum);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    load_start = 1'b1;
    byte_valid = 1'b1;
    byte_in    = 8'h01;
    @(posedge clk); #1;
    reset      = 1'b0;
    load_start = 1'b0;
    byte_valid = 1'b0;
    m_mode     = M_IDLE;
    m_wc       = 8'd0;
  endtask

  task automatic fill_random(input int nbytes);
    pl_q.delete();
    for (int i = 0; i < nbytes; i++) pl_q.push_back(8'($urandom));
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [7:0] n;
    bit         bad;
    reset      = 1'b1;
    load_start = 1'b0;
    byte_in    = 8'd0;
    byte_valid = 1'b0;
    PC         = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    probe("reset_state", 8'd0);

    // Two-word program, back-to-back bytes.
    pl_q = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h20, 8'h02, 8'h00, 8'h03};
    send_load(8'd2, 0, -1, 1'b0, 1'b0);
    probe("basic_pc0", 8'd0);
    probe("basic_pc1", 8'd1);
    probe("basic_pc2", 8'd2);
    probe("basic_pc255", 8'd255);

    // Header boundaries.
    send_load(8'd0, 0, -1, 1'b0, 1'b0);
    probe("hdr_zero", 8'd0);
    send_load(8'd40, 0, -1, 1'b0, 1'b0);
    probe("hdr_40", 8'd0);
    send_load(8'd33, 0, -1, 1'b0, 1'b0);
    probe("hdr_33", 8'd0);
    fill_random(4 * DEPTH);
    send_load(8'(DEPTH), 0, -1, 1'b0, 1'b0);
    probe("full_pc31", 8'd31);
    probe("full_pc32", 8'd32);

    // Same two-word program with byte_valid toggling.
    pl_q = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h20, 8'h02, 8'h00, 8'h03};
    send_load(8'd2, 1, -1, 1'b0, 1'b0);
    probe("toggle_pc0", 8'd0);
    probe("toggle_pc1", 8'd1);
    probe("toggle_pc2", 8'd2);

    // Reload a one-word program over the two-word one; load_start mid-payload is ignored.
    pl_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_load(8'd1, 0, -1, 1'b0, 1'b1);
    probe("reload_pc0", 8'd0);
    probe("reload_pc1", 8'd1);

    // Reset mid-payload, with load_start and a byte offered in the reset cycle.
    pl_q = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h20, 8'h02, 8'h00, 8'h03};
    send_load(8'd2, 0, 5, 1'b0, 1'b0);
    do_reset();
    probe("reset_midload", 8'd0);
    fill_random(4);
    send_load(8'd1, 2, -1, 1'b0, 1'b0);
    probe("after_reset_pc0", 8'd0);
    probe("after_reset_pc1", 8'd1);

`ifdef LOADER_CHECKSUM_EN
    pl_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_load(8'd1, 0, -1, 1'b0, 1'b0);
    probe("csum_good", 8'd0);
    send_load(8'd1, 0, -1, 1'b1, 1'b0);
    probe("csum_bad", 8'd0);
`endif

    // Randomised programs with random gaps and occasional bad headers.
    for (int t = 0; t < 12; t++) begin
      n = 8'($urandom_range(0, 9));
      if (n == 8'd9) n = 8'd40;
      bad = ($urandom_range(0, 3) == 0);
      fill_random(4 * int'(n));
      send_load(n, 2, -1, bad, 1'b0);
      probe("rand_pc0", 8'd0);
      probe("rand_pc_in", 8'($urandom_range(0, int'(n) + 1)));
      probe("rand_pc_edge", n);
      probe("rand_pc_any", 8'($urandom));
    end

    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 32, instruction-memory capacity in 32-bit words (max 255).
REQ-002 SHALL have parameter NOP_WORD, default 32'h00000000, word returned for out-of-range PC.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port load_start  input  1  single-cycle request to begin a program load.
REQ-006 SHALL have port byte_in  input  8  serial program byte.
REQ-007 SHALL have port byte_valid  input  1  byte_in carries a valid byte.
REQ-008 SHALL have port byte_ready  output  1  loader accepts byte this cycle.
REQ-009 SHALL have port PC  input  8  program counter from the processor.
REQ-010 SHALL have port instruction  output  32 (bit 0 = MSB, [0:31] ordering)  word at PC.
REQ-011 SHALL have port proc_run  output  1  program loaded; processor may execute.
REQ-012 SHALL have port load_error  output  1  last load failed.
REQ-013 SHALL have port word_count  output  8  number of words in current program.

Function
REQ-014 SHALL implement states IDLE, HEADER, PAYLOAD, CHECK, RUN, ERROR; CHECK is only reachable with the macro in REQ-029.
REQ-015 SHALL transfer a byte only on a cycle with byte_valid=1 and byte_ready=1; byte_ready SHALL be 1 exactly in HEADER, PAYLOAD and CHECK.
REQ-016 SHALL move from IDLE, RUN or ERROR to HEADER on the cycle after load_start=1; proc_run SHALL fall on that same edge.
REQ-017 In HEADER, the accepted byte SHALL be N; N=0 or N>DEPTH → ERROR; otherwise word_count←N, → PAYLOAD.
REQ-018 In PAYLOAD, SHALL pack bytes big-endian: the 1st byte of each group of 4 goes to instruction bits [0:7], the 4th to [24:31]; a word is written to imem at index 0,1,…,N-1 on acceptance of its 4th byte.
REQ-019 SHALL leave PAYLOAD after the 4N-th accepted byte: → CHECK if the macro is defined, else → RUN.
REQ-020 In RUN, instruction SHALL be combinational imem[PC] when PC<word_count, else NOP_WORD; in all other states instruction SHALL be NOP_WORD.
REQ-021 proc_run SHALL be 1 exactly in RUN; load_error SHALL be 1 exactly in ERROR.
REQ-022 Gaps (byte_valid=0) SHALL stall the load indefinitely with no state change.
REQ-023 load_start during HEADER/PAYLOAD/CHECK SHALL be ignored.
REQ-024 A reload SHALL overwrite imem words 0..N-1 only; stale words at indices ≥N SHALL be masked by REQ-020.

Reset
REQ-025 reset SHALL force state IDLE, byte counter 0, word_count 0, checksum accumulator 0.
REQ-026 Reset values: byte_ready=0, proc_run=0, load_error=0, instruction=NOP_WORD, word_count=0.
REQ-027 reset mid-load SHALL abandon the load; imem contents need not be cleared.
REQ-028 reset SHALL take priority over load_start and byte transfers in the same cycle.

Configuration
REQ-029 Macro LOADER_CHECKSUM_EN: when defined, after the payload one checksum byte SHALL be accepted in CHECK; equal to XOR of all 4N payload bytes → RUN, else → ERROR.
REQ-030 Without LOADER_CHECKSUM_EN, no CHECK state, no accumulator; PAYLOAD → RUN directly.

Structure
REQ-031 State encodings, NOP_WORD default and byte-lane constants SHALL live in the shared state-definitions header used by the processor blocks.
REQ-032 The storage SHALL be a sub-module imem (synchronous single write port, combinational read port, DEPTH×32).

Verification
REQ-033 Load N=2, bytes 20 01 00 05 | 20 02 00 03 (no gaps) → proc_run=1 one cycle after last byte; PC=0 → 32'h20010005, PC=1 → 32'h20020003, PC=2 → 32'h00000000.
REQ-034 Header 8'h00, then header 8'd40 (DEPTH=32) → load_error=1, byte_ready=0, proc_run=0 after each.
REQ-035 Same load as REQ-033 with byte_valid toggled every other cycle → identical imem contents, completion 1 cycle after last accepted byte.
REQ-036 reset asserted after 5 of 8 payload bytes → next cycle all outputs at reset values; fresh load_start with N=1 succeeds.
REQ-037 With LOADER_CHECKSUM_EN, N=1 word AA BB CC DD, checksum 8'h00 → RUN; checksum 8'h01 → ERROR.
REQ-038 Reload from RUN with N=1 over an N=2 program → proc_run 0 during load, then PC=1 returns NOP_WORD.
